imm_gen_pipe: RTL

Registered, handshaked immediate generator for the decode stage: accepts a fetched instruction plus a sideband tag (typically the PC) on a valid/ready interface. It emits the sign-extended immediate, its format code and the tag one cycle later. Generalised to XLEN of 32 or 64 and to CSR zero-immediates, with a 2-entry skid buffer so the fetch-to-decode path is fully registered at 1 instruction/cycle.

---
 rtl/imm_gen_pipe.sv | 134 +++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// Registered valid/ready immediate generator with a 2-entry skid buffer (output reg + skid reg).
// Optional feature macro: IMM_GEN_ZICSR_EN adds the CSR zero-immediate (Z) format for SYSTEM.

package rv32i_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_RSVD = 3'd7
    } fmt_e;
endpackage

module imm_gen_pipe #(
    parameter int XLEN  = rv32i_pkg::XLEN,
    parameter int TAG_W = 32
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [rv32i_pkg::ILEN-1:0] instr_in,
    input  logic [TAG_W-1:0]           tag_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            imm_out,
    output logic [2:0]                 fmt_out,
    output logic [TAG_W-1:0]           tag_out
);
    import rv32i_pkg::*;

    typedef struct packed {
        logic             valid;
        fmt_e             fmt;
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t oreg;
    entry_t skid;
    entry_t dec;

    logic in_fire;
    logic out_fire;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec.tag   = tag_in;
        dec.fmt   = FMT_NONE;
        dec.imm   = '0;
        unique case (instr_in[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec.fmt = FMT_I;
                dec.imm = XLEN'(signed'(instr_in[31:20]));
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec.fmt = FMT_I;
                    dec.imm = XLEN'(signed'(instr_in[31:20]));
                end
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                dec.imm = XLEN'(signed'({instr_in[31:25], instr_in[11:7]}));
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                dec.imm = XLEN'(signed'({instr_in[31], instr_in[7], instr_in[30:25],
                                         instr_in[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                dec.imm = XLEN'(signed'({instr_in[31:12], 12'b0}));
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                dec.imm = XLEN'(signed'({instr_in[31], instr_in[19:12], instr_in[20],
                                         instr_in[30:21], 1'b0}));
            end
`ifdef IMM_GEN_ZICSR_EN
            7'b1110011: begin
                // CSR immediate forms are funct3 101/110/111; the rest of SYSTEM has no immediate.
                if (instr_in[14] && (instr_in[13:12] != 2'b00)) begin
                    dec.fmt = FMT_Z;
                    dec.imm = XLEN'(instr_in[19:15]);
                end
            end
`endif
            default: begin
                dec.fmt = FMT_NONE;
                dec.imm = '0;
            end
        endcase
    end

    // The skid entry is only ever full while the output entry is full, so !skid.valid
    // is exactly "there is room for one more instruction".
    assign in_ready = !skid.valid;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = oreg.valid && out_ready;

    assign out_valid = oreg.valid;
    assign imm_out   = oreg.imm;
    assign fmt_out   = oreg.fmt;
    assign tag_out   = oreg.tag;

    // NOTE: both entries are reset in full (not just valid) so outputs read 0 after reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            oreg <= '0;
            skid <= '0;
        end else if (!oreg.valid || out_fire) begin
            if (skid.valid) begin
                oreg <= skid;
                skid <= '0;
            end else if (in_fire) begin
                oreg <= dec;
            end else begin
                oreg.valid <= 1'b0;
            end
        end else if (in_fire) begin
            skid <= dec;
        end
    end

endmodule
